// File: rtl/freg_dbg_pkg.sv
// Shared definitions for the floating-point register-file debug dump path:
// state encoding, default widths and record geometry.
package freg_dbg_pkg;

    localparam int DEF_SEL_W  = 5;
    localparam int DEF_DATA_W = 32;

    // One index byte followed by the register data bytes.
    function automatic int rec_bytes(input int data_w);
        return data_w / 8 + 1;
    endfunction

    localparam int RECORD_BYTES = rec_bytes(DEF_DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/freg_dump_ser.sv
// Record serializer: snapshots one register value and presents it as an
// index byte plus data bytes (MSB first) on a valid/ready byte stream.
module freg_dump_ser
    import freg_dbg_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [SEL_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [7:0]        o_data,
    output logic              o_valid,
    output logic              o_record_last
);

    localparam int NBYTES = DATA_W / 8;
    localparam int REC    = rec_bytes(DATA_W);
    localparam int CNT_W  = $clog2(REC);

    logic [DATA_W-1:0] r_shadow;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    logic              w_xfer;
    logic              w_last_byte;
    logic [7:0]        w_bytes [REC];

    assign w_xfer        = r_valid && i_ready;
    assign w_last_byte   = (r_cnt == CNT_W'(REC - 1));
    assign o_record_last = w_xfer && w_last_byte;
    assign o_valid       = r_valid;

    assign w_bytes[0] = 8'(i_idx);

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign w_bytes[gi+1] = r_shadow[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    // Output is forced to zero whenever no byte is on offer.
    always_comb begin
        o_data = 8'h00;
        for (int b = 0; b < REC; b++) begin
            if (r_valid && (r_cnt == CNT_W'(b))) begin
                o_data = w_bytes[b];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_shadow <= i_data;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
        end else if (w_xfer) begin
            if (w_last_byte) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freg_dump_reader.sv
// Debug dump reader: walks an index range of the FP register file through
// its display-select port and streams each value as a byte record.
module freg_dump_reader
    import freg_dbg_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [SEL_W-1:0]  iFirst,
    input  logic [SEL_W-1:0]  iLast,
    output logic [SEL_W-1:0]  oRegSel,
    input  logic [DATA_W-1:0] iRegData,
    output logic [7:0]        oTxData,
    output logic              oTxValid,
    input  logic              iTxReady,
    output logic              oBusy,
    output logic              oDone
);

    state_t           r_state;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] r_last;
    logic             r_abort;
    logic             r_busy;
    logic             r_done;

    logic             w_abort;
    logic             w_ser_load;
    logic             w_rec_last;

    // An abort raised in the same cycle counts as already pending.
    assign w_abort    = r_abort || iAbort;
    assign w_ser_load = (r_state == S_LOAD) && !w_abort;

    assign oRegSel = r_idx;
    assign oBusy   = r_busy;
    assign oDone   = r_done;

    freg_dump_ser #(
        .SEL_W  (SEL_W),
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk         (iCLK),
        .i_rst_n       (iRST_N),
        .i_load        (w_ser_load),
        .i_idx         (r_idx),
        .i_data        (iRegData),
        .i_ready       (iTxReady),
        .o_data        (oTxData),
        .o_valid       (oTxValid),
        .o_record_last (w_rec_last)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        if (iFirst <= iLast) begin
                            r_idx   <= iFirst;
                            r_last  <= iLast;
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    r_abort <= w_abort;
                    if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_abort <= w_abort;
                    if (w_rec_last) begin
                        // idx stops at last, so the top index never wraps.
                        if ((r_idx == r_last) || w_abort) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + SEL_W'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_abort <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freg_dump_reader.sv
// Directed bench for freg_dump_reader with a behavioural register file.
module tb_freg_dump_reader;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iStart;
    logic        iAbort;
    logic [4:0]  iFirst;
    logic [4:0]  iLast;
    logic [4:0]  oRegSel;
    logic [31:0] iRegData;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady;
    logic        oBusy;
    logic        oDone;

    logic [31:0] f [32];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int          done_cyc;
    int          first_cyc;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    always #5 iCLK = ~iCLK;

    assign iRegData = f[oRegSel];

    freg_dump_reader dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iStart   (iStart),
        .iAbort   (iAbort),
        .iFirst   (iFirst),
        .iLast    (iLast),
        .oRegSel  (oRegSel),
        .iRegData (iRegData),
        .oTxData  (oTxData),
        .oTxValid (oTxValid),
        .iTxReady (iTxReady),
        .oBusy    (oBusy),
        .oDone    (oDone)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input int first, input int last);
        exp_q.delete();
        for (int i = first; i <= last; i++) begin
            exp_q.push_back(8'(i));
            for (int b = 3; b >= 0; b--) exp_q.push_back(f[i][8*b +: 8]);
        end
    endtask

    task automatic cmp_bytes(input string tag);
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
    endtask

    // mode 0: ready high; 1: ready toggles with a 7-cycle stall;
    // 2: snapshot writes to f4 in LOAD and SEND.
    task automatic dump(input logic [4:0] first, input logic [4:0] last,
                        input int mode, input int abort_at, input int maxc);
        int   cyc;
        logic rdy;
        logic stalled;
        logic aborted;
        logic [7:0] prev_data;
        got.delete();
        done_cyc  = -1;
        first_cyc = -1;
        stalled   = 1'b0;
        aborted   = 1'b0;
        prev_data = 8'h00;
        @(negedge iCLK);
        iStart = 1'b1; iFirst = first; iLast = last; iTxReady = 1'b1;
        cyc = 0;
        forever begin
            @(negedge iCLK);
            cyc++;
            iStart = 1'b0;
            iAbort = 1'b0;
            if (oDone) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > maxc) begin
                check("dump_timeout", 64'(cyc), 64'(maxc));
                break;
            end
            if (mode == 2 && cyc == 1) f[4] = 32'h1111_1111;
            if (mode == 2 && cyc == 3) f[4] = 32'h2222_2222;
            rdy = (mode == 1) ? ((cyc >= 10 && cyc < 17) ? 1'b0 : (cyc % 2 == 0)) : 1'b1;
            if (stalled) begin
                check("stall_valid", oTxValid, 1'b1);
                check("stall_data", oTxData, prev_data);
            end
            if (abort_at >= 0 && !aborted && oTxValid && got.size() == abort_at) begin
                iAbort  = 1'b1;
                aborted = 1'b1;
            end
            iTxReady = rdy;
            if (oTxValid && rdy) begin
                if (first_cyc < 0) first_cyc = cyc;
                got.push_back(oTxData);
            end
            stalled   = oTxValid && !rdy;
            prev_data = oTxData;
        end
        // Start request during DONE must be ignored.
        if (done_cyc >= 0) begin
            iStart = 1'b1;
            @(negedge iCLK);
            iStart = 1'b0;
            check("done_pulse_width", oDone, 1'b0);
            check("start_in_done_ignored", oBusy, 1'b0);
        end
        iTxReady = 1'b1;
        $display("dump %0d..%0d mode %0d: %0d bytes, done at cycle %0d",
                 first, last, mode, got.size(), done_cyc);
    endtask

    initial begin
        iRST_N = 1'b0; iStart = 1'b0; iAbort = 1'b0;
        iFirst = '0; iLast = '0; iTxReady = 1'b1;
        for (int i = 0; i < 32; i++) f[i] = 32'h0;
        repeat (3) @(negedge iCLK);
        check("rst_valid", oTxValid, 1'b0);
        check("rst_busy",  oBusy,    1'b0);
        check("rst_done",  oDone,    1'b0);
        check("rst_sel",   oRegSel,  5'd0);
        check("rst_data",  oTxData,  8'h00);
        iRST_N = 1'b1;

        // Single register.
        f[5] = 32'h3F80_0000;
        dump(5'd5, 5'd5, 0, -1, 50);
        exp_q = {8'h05, 8'h3F, 8'h80, 8'h00, 8'h00};
        cmp_bytes("single");
        check("single_first_cyc", 64'(first_cyc), 64'd2);
        check("single_done_cyc",  64'(done_cyc),  64'd7);

        // Full dump.
        for (int i = 0; i < 32; i++) f[i] = 32'hA500_0000 | 32'(i);
        dump(5'd0, 5'd31, 0, -1, 400);
        build_exp(0, 31);
        cmp_bytes("full");
        check("full_done_cyc", 64'(done_cyc), 64'd193);
        check("full_no_wrap",  oRegSel, 5'd31);

        // Backpressure.
        dump(5'd2, 5'd3, 1, -1, 200);
        build_exp(2, 3);
        cmp_bytes("bp");

        // Snapshot.
        f[4] = 32'h0;
        dump(5'd4, 5'd4, 2, -1, 50);
        exp_q = {8'h04, 8'h11, 8'h11, 8'h11, 8'h11};
        cmp_bytes("snap");

        // Abort during byte 2 of record 7 (global byte 7).
        f[4] = 32'hA500_0004;
        dump(5'd6, 5'd20, 0, 7, 200);
        build_exp(6, 7);
        cmp_bytes("abort");
        check("abort_done_cyc", 64'(done_cyc), 64'd13);

        // Empty range.
        dump(5'd9, 5'd3, 0, -1, 20);
        check("empty_len",      64'(got.size()), 64'd0);
        check("empty_done_cyc", 64'(done_cyc),   64'd1);

        // Reset mid-stream, then a clean restart.
        @(negedge iCLK);
        iStart = 1'b1; iFirst = 5'd10; iLast = 5'd12; iTxReady = 1'b1;
        @(negedge iCLK); iStart = 1'b0;
        repeat (3) @(negedge iCLK);
        check("pre_rst_valid", oTxValid, 1'b1);
        iRST_N = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        check("mid_rst_valid", oTxValid, 1'b0);
        check("mid_rst_busy",  oBusy,    1'b0);
        check("mid_rst_done",  oDone,    1'b0);
        check("mid_rst_sel",   oRegSel,  5'd0);
        check("mid_rst_data",  oTxData,  8'h00);
        dump(5'd10, 5'd11, 0, -1, 100);
        build_exp(10, 11);
        cmp_bytes("restart");
        check("restart_done_cyc", 64'(done_cyc), 64'd13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freg_dump_reader.md
Name: freg_dump_reader

Overview:
- Debug-side reader for the floating-point register file.
- Walks a programmed index range through the file's asynchronous display-select read port and captures each 32-bit value.
- Streams each captured value as a 5-byte record over a valid/ready byte interface that feeds the debug UART transmitter.
- Reads only; never writes the register file.

Parameters:
- SEL_W, 5, register index width (32 registers).
- DATA_W, 32, register data width; must be a multiple of 8.
- NBYTES, DATA_W/8 (4), data bytes per record.

Ports:
- iCLK  in  1  system clock; all state updates on posedge.
- iRST_N  in  1  reset, synchronous, active-low.
- iStart  in  1  single-cycle request to begin a dump; honoured only in IDLE.
- iAbort  in  1  stop the dump at the next record-byte boundary.
- iFirst  in  SEL_W  first register index, sampled with iStart.
- iLast  in  SEL_W  last register index, inclusive, sampled with iStart.
- oRegSel  out  SEL_W  index driven to the register file display-select input.
- iRegData  in  DATA_W  combinational read data returned for oRegSel.
- oTxData  out  8  byte presented to the transmitter.
- oTxValid  out  1  oTxData is valid.
- iTxReady  in  1  transmitter accepts the byte this cycle.
- oBusy  out  1  high from the cycle after an accepted iStart until DONE.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset (iRST_N=0 at posedge):
  - State goes to IDLE.
  - oRegSel=0, oTxData=0, oTxValid=0, oBusy=0, oDone=0.
  - Index, last-index, byte counter and shadow register are cleared.
  - Reset mid-stream drops oTxValid immediately; the partial record is discarded.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - iStart=1 with iFirst<=iLast: latch iFirst into idx and iLast into last; go to LOAD.
  - iStart=1 with iFirst>iLast: go to DONE; no bytes are sent.
  - iStart is ignored in every other state.
- LOAD (exactly one cycle):
  - oRegSel=idx.
  - Capture iRegData into the shadow register at the end of the cycle.
  - Clear the byte counter; go to SEND.
  - The snapshot is the value present in the LOAD cycle; later register-file writes do not affect this record.
- SEND:
  - oTxValid=1.
  - Byte 0 = {(8-SEL_W)'b0, idx}.
  - Bytes 1..NBYTES = shadow data, MSB first.
  - A byte transfers when oTxValid&&iTxReady.
  - oTxData must stay stable while oTxValid&&!iTxReady.
  - oTxValid is never withdrawn before a transfer, except by reset.
  - After the last byte transfers:
    - idx==last or abort pending: go to DONE.
    - otherwise: idx<=idx+1, go to LOAD.
- Index wrap: idx never increments past last, so idx=31 never wraps to 0.
- iAbort:
  - Sets an abort-pending flag in any non-IDLE state.
  - LOAD with abort pending: go straight to DONE.
  - SEND with abort pending: finish the current record (no partial records), then go to DONE.
  - The flag clears in DONE.
- DONE: oDone=1 for one cycle, oBusy=0, then return to IDLE. iStart in the DONE cycle is ignored.
- oBusy=1 in LOAD and SEND.
- Latency, with iTxReady held high:
  - iStart at cycle 0; LOAD at cycle 1; first byte valid at cycle 2.
  - Each register takes 1+(NBYTES+1)=6 cycles.
  - A 32-register dump takes 192 cycles, with oDone at cycle 193.
- oRegSel holds idx in all states.

Decomposition:
- Shared package (freg_dbg_pkg):
  - State encoding constants S_IDLE, S_LOAD, S_SEND, S_DONE.
  - SEL_W and DATA_W defaults.
  - RECORD_BYTES = NBYTES+1.
- One natural sub-module, freg_dump_ser:
  - Shadow register, byte counter and MSB-first byte mux.
  - Valid/ready hold logic.
  - Output: record_last pulse.
- The top-level block keeps the FSM, index/range logic and abort flag.

Test Plan:
- Single register: preload f5=32'h3F800000; iFirst=iLast=5; ready=1. Required: bytes 05,3F,80,00,00 on cycles 2-6; oDone pulse at cycle 7.
- Full dump: f[i]=32'hA5000000|i; range 0..31; ready=1. Required: 160 bytes, records in index order, oDone at cycle 193, no index wrap.
- Backpressure: range 2..3; iTxReady toggles 1010... and is held low 7 cycles mid-record. Required: oTxData/oTxValid stable while stalled; byte sequence unchanged.
- Snapshot: range 4..4; write f4=32'h11111111 at LOAD, then f4=32'h22222222 during SEND. Required: the record carries 11111111.
- Abort and empty range:
  - iAbort during byte 2 of record 7 in range 6..20. Required: record 7 completes, then oDone; no record 8.
  - iFirst=9, iLast=3. Required: oDone next cycle, zero bytes.
- Reset mid-stream: iRST_N=0 for one posedge during SEND. Required: all outputs 0 next cycle; a new iStart restarts cleanly at iFirst.
